trng_sequencer: RTL and testbench

Control sequencer for the `dual_trng` entropy core in the TRNG peripheral. It runs the core through reset, calibration, warm-up and continuous sampling, and drives `iRst`/`iEn`/`iCalib`/`iRead`. Each `oRandom` word is captured into a small FIFO that the register interface pops, so software no longer toggles control bits by hand. The block sits between the register bank and `dual_trng`.

---
 rtl/trng_seq_pkg.sv | 37 +++
 rtl/trng_seq_fifo.sv | 67 ++++++
 rtl/trng_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_trng_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trng_seq_pkg
// Purpose  : Shared types, default parameters and helpers for trng_sequencer.
// Contents : trng_seq_state_t  - sequencer state encoding
//            DEF_*             - default FIFO depth, warm-up, timeout, repeat limit
//            clog2()           - ceiling log2 for pointer widths
// Revision : 1.0 - initial release
// ============================================================================
package trng_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_CALIB  = 3'd2,
    ST_WARMUP = 3'd3,
    ST_RUN    = 3'd4,
    ST_ACK    = 3'd5,
    ST_ERROR  = 3'd6
  } trng_seq_state_t;

  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_WARMUP_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int DEF_REP_LIMIT      = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trng_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trng_seq_fifo
// Purpose  : Synchronous DEPTH x 32 FIFO with show-ahead read data.
// Ports    : clk, rst_n        - clock, async active-low reset
//            push_i, wr_data_i - write strobe / data (ignored when full)
//            pop_i             - remove head (ignored when empty)
//            rd_data_o         - head word, 0 when empty
//            full_o, empty_o   - status flags
//            count_o           - words held
// Revision : 1.0 - initial release
// ============================================================================
module trng_seq_fifo
  import trng_seq_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [31:0]               wr_data_i,
  input  logic                      pop_i,
  output logic [31:0]               rd_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [clog2(DEPTH):0]     count_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the AW-bit pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? 32'd0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/trng_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trng_sequencer
// Purpose  : Runs the dual_trng core through reset, calibration, warm-up and
//            continuous sampling; buffers each accepted word in a FIFO.
// Ports    : start/stop        - session control pulses (stop wins)
//            calib_cycles      - calibration length, latched on start
//            trng_rst/en/calib/read - core controls
//            trng_ready/random - core handshake and data
//            pop, rd_data, rd_valid, fifo_count - FIFO read side
//            busy, err, irq    - status
// Config   : TRNG_SEQ_HEALTH_EN - compiles in the repetition-count health test
// Revision : 1.0 - initial release
// ============================================================================
module trng_sequencer
  import trng_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int REP_LIMIT      = DEF_REP_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] calib_cycles,
  output logic        trng_rst,
  output logic        trng_en,
  output logic        trng_calib,
  output logic        trng_read,
  input  logic        trng_ready,
  input  logic [31:0] trng_random,
  input  logic        pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [4:0]  fifo_count,
  output logic        busy,
  output logic        err,
  output logic        irq
);

  localparam int          CW        = clog2(FIFO_DEPTH);
  localparam logic [31:0] WARM_LAST = 32'(WARMUP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  trng_seq_state_t state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;      // shared CALIB / WARMUP phase counter
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     calib_q, calib_d;
  logic            err_q, err_d;
  logic            push;
  logic            health_trip;
  logic            fifo_full, fifo_empty;
  logic [CW:0]     fifo_cnt;

`ifdef TRNG_SEQ_HEALTH_EN
  logic [31:0] prev_q;
  logic        prev_vld_q;
  logic [7:0]  rep_q;
  logic        accept, rep_match;

  assign accept      = (state_q == ST_RUN) && trng_ready && !fifo_full && !stop;
  assign rep_match   = prev_vld_q && (trng_random == prev_q);
  // rep_q counts repeats already seen; one more makes REP_LIMIT identical words.
  assign health_trip = rep_match && (rep_q == 8'(REP_LIMIT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
    end else if (state_q == ST_RESET) begin
      rep_q <= '0;
    end else if (accept) begin
      prev_q     <= trng_random;
      prev_vld_q <= 1'b1;
      rep_q      <= rep_match ? rep_q + 8'd1 : 8'd0;
    end
  end
`else
  assign health_trip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      calib_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      calib_q <= calib_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    calib_d = calib_q;
    err_d   = err_q;
    push    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            calib_d = calib_cycles;
            state_d = ST_RESET;
          end
        end
        ST_RESET: begin
          cnt_d   = '0;
          state_d = (calib_q == 32'd0) ? ST_WARMUP : ST_CALIB;
        end
        ST_CALIB: begin
          if (cnt_q == calib_q - 32'd1) begin
            cnt_d   = '0;
            state_d = ST_WARMUP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_WARMUP: begin
          if (cnt_q == WARM_LAST) begin
            tmo_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_RUN: begin
          if (trng_ready) begin
            // A full FIFO stalls here without advancing the timeout.
            if (!fifo_full) begin
              if (health_trip) begin
                err_d   = 1'b1;
                state_d = ST_ERROR;
              end else begin
                push    = 1'b1;
                state_d = ST_ACK;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        ST_ACK: begin
          if (!trng_ready) begin
            tmo_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_ERROR: begin
          if (start) begin
            err_d   = 1'b0;
            calib_d = calib_cycles;
            state_d = ST_RESET;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  trng_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .wr_data_i (trng_random),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign trng_rst   = (state_q == ST_RESET) || (state_q == ST_ERROR);
  assign trng_en    = (state_q == ST_CALIB) || (state_q == ST_WARMUP) ||
                      (state_q == ST_RUN)   || (state_q == ST_ACK);
  assign trng_calib = (state_q == ST_CALIB);
  assign trng_read  = (state_q == ST_ACK);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign err        = err_q;
  assign rd_valid   = !fifo_empty;
  assign fifo_count = 5'(fifo_cnt);
  assign irq        = fifo_full | err_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_sequencer
// Purpose  : Self-checking bench for trng_sequencer: control-sequence table,
//            FIFO fill/stall, health test and a randomized handshake phase
//            checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_sequencer;

  localparam int DEPTH = 4;
  localparam int WARM  = 16;
  localparam int TMO   = 10;
  localparam int REP   = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, pop;
  logic [31:0] calib_cycles;
  logic        trng_rst, trng_en, trng_calib, trng_read;
  logic        trng_ready = 1'b0;
  logic [31:0] trng_random = 32'd0;
  logic [31:0] rd_data;
  logic        rd_valid, busy, err, irq;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  trng_sequencer #(
    .FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARM), .TIMEOUT_CYCLES(TMO), .REP_LIMIT(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .calib_cycles(calib_cycles),
    .trng_rst(trng_rst), .trng_en(trng_en), .trng_calib(trng_calib), .trng_read(trng_read),
    .trng_ready(trng_ready), .trng_random(trng_random), .pop(pop), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .busy(busy), .err(err), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- core model ----------------
  // mode 0: idle (ready low, word counter cleared)
  // mode 1: words cfg_base+n (or cfg_base repeated if cfg_fixed), no gap
  // mode 2: random words, random 0..3 cycle gap after each read
  int          core_mode = 0;
  logic [31:0] cfg_base  = 32'd0;
  bit          cfg_fixed = 1'b0;
  int          cfg_limit = 1000000;
  int          wcnt = 0;
  int          gap  = 0;
  logic [31:0] rnd;

  always @(negedge clk) begin
    if (core_mode == 0) begin
      trng_ready = 1'b0;
      wcnt       = 0;
      gap        = 0;
    end else if (trng_ready && trng_read) begin
      trng_ready = 1'b0;
      gap        = (core_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    end else if (!trng_ready && trng_en && wcnt < cfg_limit) begin
      if (gap > 0) gap--;
      else begin
        rnd = $urandom;
        if (core_mode == 2)  trng_random = {rnd[31:16], 16'(wcnt)};
        else if (cfg_fixed)  trng_random = cfg_base;
        else                 trng_random = cfg_base + 32'(wcnt);
        trng_ready = 1'b1;
        wcnt++;
      end
    end
  end

  // ---------------- control-sequence table ----------------
  typedef struct {
    logic        start;
    logic        stop;
    logic [31:0] calib;
    int          reps;
    logic [5:0]  exp;   // {trng_rst, trng_en, trng_calib, trng_read, busy, err}
  } vec_t;

  vec_t tbl [15];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [31:0] c);
    @(negedge clk) start = 1'b1; calib_cycles = c;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) pop = rd_valid;
    end
    @(negedge clk) pop = 1'b0;
  endtask

  logic [31:0] exp_q [$];
  bit          ack_m;
  logic        s_rdy, s_pop;
  logic [31:0] s_dat;
  int          n;
  bit          acc;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pop = 1'b0; calib_cycles = 32'd0;

    tbl[0]  = '{1'b0, 1'b0, 32'd0, 2,  6'b000000};  // idle after reset
    tbl[1]  = '{1'b1, 1'b0, 32'd5, 1,  6'b100010};  // start -> RESET
    tbl[2]  = '{1'b0, 1'b0, 32'd0, 5,  6'b011010};  // CALIB x5 (latched)
    tbl[3]  = '{1'b0, 1'b0, 32'd0, 16, 6'b010010};  // WARMUP
    tbl[4]  = '{1'b0, 1'b0, 32'd0, 3,  6'b010010};  // RUN
    tbl[5]  = '{1'b1, 1'b0, 32'd0, 1,  6'b010010};  // start ignored in RUN
    tbl[6]  = '{1'b0, 1'b1, 32'd0, 1,  6'b000000};  // stop -> IDLE
    tbl[7]  = '{1'b1, 1'b1, 32'd7, 1,  6'b000000};  // start+stop -> IDLE
    tbl[8]  = '{1'b1, 1'b0, 32'd0, 1,  6'b100010};  // calib 0 start
    tbl[9]  = '{1'b0, 1'b0, 32'd0, 16, 6'b010010};  // straight to WARMUP
    tbl[10] = '{1'b0, 1'b0, 32'd0, 10, 6'b010010};  // RUN waiting 10 cycles
    tbl[11] = '{1'b0, 1'b0, 32'd0, 2,  6'b100001};  // ERROR after timeout
    tbl[12] = '{1'b1, 1'b0, 32'd3, 1,  6'b100010};  // start clears err
    tbl[13] = '{1'b0, 1'b0, 32'd0, 2,  6'b011010};  // CALIB
    tbl[14] = '{1'b0, 1'b1, 32'd0, 1,  6'b000000};  // stop mid CALIB

    // reset values
    #12;
    check("rst_ctrl", {26'd0, trng_rst, trng_en, trng_calib, trng_read, busy, err}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        @(negedge clk);
        start        = (r == 0) ? tbl[v].start : 1'b0;
        stop         = (r == 0) ? tbl[v].stop  : 1'b0;
        calib_cycles = tbl[v].calib;
        cyc();
        check($sformatf("tbl%0d_%0d_ctrl", v, r),
              {26'd0, trng_rst, trng_en, trng_calib, trng_read, busy, err}, {26'd0, tbl[v].exp});
        check($sformatf("tbl%0d_%0d_irq", v, r), {31'd0, irq}, {31'd0, tbl[v].exp[0]});
      end
    end
    @(negedge clk) start = 1'b0; stop = 1'b0;

    // ---------------- FIFO fill, stall and pop ----------------
    cfg_base = 32'hA5A5_0001; cfg_fixed = 1'b0; cfg_limit = 1000000; core_mode = 1;
    pulse_start(32'd5);
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (fifo_count == 5'd4) break;
    end
    check("fill_count", {27'd0, fifo_count}, 32'd4);
    check("fill_irq", {31'd0, irq}, 32'd1);
    check("fill_head", rd_data, 32'hA5A5_0001);
    repeat (3) cyc();
    check("stall_read", {31'd0, trng_read}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_count", {27'd0, fifo_count}, 32'd4);
    @(negedge clk) pop = 1'b1;
    cyc();
    check("pop_head", rd_data, 32'hA5A5_0002);
    check("pop_count", {27'd0, fifo_count}, 32'd3);
    @(negedge clk) pop = 1'b0;
    cyc();
    check("word5_count", {27'd0, fifo_count}, 32'd4);
    check("word5_read", {31'd0, trng_read}, 32'd1);
    @(negedge clk) stop = 1'b1; core_mode = 0;
    cyc();
    check("stop_ctrl", {28'd0, trng_rst, trng_en, trng_calib, trng_read}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_count", {27'd0, fifo_count}, 32'd4);
    @(negedge clk) stop = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("drain_w%0d", k), rd_data, 32'hA5A5_0000 + 32'(k));
      @(negedge clk) pop = 1'b1;
      @(negedge clk) pop = 1'b0;
    end
    check("drain_empty", {31'd0, rd_valid}, 32'd0);

    // ---------------- repetition health test ----------------
    @(negedge clk);
    cfg_base = 32'h1234_5678; cfg_fixed = 1'b1; cfg_limit = 3; core_mode = 1;
    pulse_start(32'd0);
`ifdef TRNG_SEQ_HEALTH_EN
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (err) break;
    end
    check("health_err", {31'd0, err}, 32'd1);
    check("health_count", {27'd0, fifo_count}, 32'd2);
    check("health_rst", {31'd0, trng_rst}, 32'd1);
`else
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (fifo_count == 5'd3) break;
    end
    check("rep_count", {27'd0, fifo_count}, 32'd3);
    check("rep_no_err", {31'd0, err}, 32'd0);
`endif
    // both builds end in ERROR (trip or timeout once the core stops)
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (!busy) break;
    end
    check("to_error_busy", {31'd0, busy}, 32'd0);
    check("to_error_err", {31'd0, err}, 32'd1);
    check("to_error_irq", {31'd0, irq}, 32'd1);
    core_mode = 0; cfg_fixed = 1'b0; cfg_limit = 1000000;
    drain();
    check("pre_rand_empty", {27'd0, fifo_count}, 32'd0);

    // ---------------- randomized handshake vs reference model ----------------
    pulse_start(32'd0);
    check("restart_err", {31'd0, err}, 32'd0);
    check("restart_rst", {31'd0, trng_rst}, 32'd1);
    repeat (WARM + 1) @(negedge clk);
    core_mode = 2;
    exp_q.delete();
    ack_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pop = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      s_rdy = trng_ready; s_dat = trng_random; s_pop = pop;
      n   = exp_q.size();
      acc = !ack_m && s_rdy && (n < DEPTH);
      if (s_pop && n > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(s_dat);
      if (acc) ack_m = 1'b1;
      else if (ack_m && !s_rdy) ack_m = 1'b0;
      #1;
      check($sformatf("rnd%0d_count", i), {27'd0, fifo_count}, 32'(exp_q.size()));
      check($sformatf("rnd%0d_valid", i), {31'd0, rd_valid}, {31'd0, exp_q.size() > 0});
      check($sformatf("rnd%0d_data", i), rd_data, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
      check($sformatf("rnd%0d_read", i), {31'd0, trng_read}, {31'd0, ack_m});
      check($sformatf("rnd%0d_irq", i), {31'd0, irq}, {31'd0, exp_q.size() == DEPTH});
      check($sformatf("rnd%0d_busy", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    pop = 1'b0;
    core_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
